fixed_point_mac: RTL and testbench
==================================

Name: fixed_point_mac

Overview:
- Pipelined, signed, fixed-point multiply-accumulate unit; next generation of the combinational fixed-point multiplier.
- Adds independent input/output Q-formats, accumulation over a group of beats, rescaling with saturation, and valid/ready flow control with backpressure.
- Sits between operand fetch (feature-map/weight streams) and output write-back in the convolution datapath; one instance per PE lane.

Parameters:
- WORD_WIDTH_IN, 16: operand width, two's complement.
- FRAC_BITS_IN, 8: fractional bits of each operand. Product has 2*FRAC_BITS_IN fractional bits.
- ACC_WIDTH, 40: accumulator width. Must be >= 2*WORD_WIDTH_IN.
- WORD_WIDTH_OUT, 16: result width, two's complement.
- FRAC_BITS_OUT, 8: fractional bits of result. Must satisfy SHIFT = 2*FRAC_BITS_IN - FRAC_BITS_OUT >= 1.
- PIPE_STAGES, 2: product register stages after the multiplier array. Must be >= 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_last  input  1  last beat of accumulation group
- multiplier  input  WORD_WIDTH_IN  signed operand A
- multiplicand  input  WORD_WIDTH_IN  signed operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WORD_WIDTH_OUT  scaled, rounded, saturated group sum
- out_sat  output  1  result was clipped; qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: in_ready=1, out_valid=0, result=0, out_sat=0. Accumulator=0, all pipeline valid bits=0, FSM=ACC_IDLE.
- Reset mid-group: any partial sum is discarded and in-flight beats are dropped. The first beat after reset starts a new group.
- Global advance: advance = !out_valid || out_ready. in_ready = advance, combinational. No other stall source exists.
- A beat is accepted when in_valid && in_ready.
- Pipeline registers (product, last flag, valid flag) shift only when advance=1. Bubbles propagate as valid=0.
- Multiply: full signed 2*WORD_WIDTH_IN product from a combinational baugh_wooley_mult, then PIPE_STAGES registers.
- Accumulate stage: sign-extend the product to ACC_WIDTH. sum = acc + product, wrapping modulo 2^ACC_WIDTH with no detection.
- FSM:
  - ACC_IDLE: acc=0.
  - ACC_IDLE -> ACC_BUSY on a valid non-last beat; acc <= product.
  - ACC_BUSY: acc <= sum on each valid non-last beat.
  - On a valid last beat in either state: load the output register from sum (acc=0 in ACC_IDLE), clear acc, go to ACC_IDLE.
- Single-beat groups (in_last on the first beat) are legal.
- Scaling: arithmetic shift right of sum by SHIFT, rounded per the optional feature.
- Saturation: if the shifted value is outside [-2^(WORD_WIDTH_OUT-1), 2^(WORD_WIDTH_OUT-1)-1], clamp to the bound and set out_sat=1.
- Latency: a last beat accepted at cycle T gives out_valid=1 at T+PIPE_STAGES+1, assuming no stall.
- Throughput: one beat per cycle.
- Output register: holds result/out_sat stable while out_valid && !out_ready. Clears out_valid on a handshake unless a new result loads in the same cycle (back-to-back results allowed).
- Simultaneous handshake and new last-beat arrival: the new result replaces the old one in the same cycle, with no gap.

Optional Feature:
- Macro: FIXED_POINT_MAC_ROUND_EN.
- Defined: round half-up. Add 2^(SHIFT-1) to sum before the shift; the addition is done at ACC_WIDTH+1 bits so it cannot wrap.
- Undefined: truncate, i.e. floor toward minus infinity via the arithmetic shift. No adder is present.

Decomposition:
- fixed_point_pkg:
  - SHIFT localparam helper function.
  - sat_signed(value, width) function.
  - acc_state_e enum {ACC_IDLE, ACC_BUSY}.
- Sub-module fixed_point_round_sat: combinational round/shift/saturate from ACC_WIDTH to WORD_WIDTH_OUT, producing out_sat. Reused by future requantisation blocks.
- Multiplier core: existing baugh_wooley_mult instance.

Test Plan (defaults, Q8.8 in/out, SHIFT=8):
- Single beat: 0x0180 x 0x0200, in_last=1 -> result=0x0300, out_sat=0, out_valid at T+3.
- Group of 3 beats of 0x0100 x 0x0100, last on beat 3 -> one result 0x0300. No out_valid on beats 1-2.
- Negative: 0xFE80 x 0x0200 (-1.5 x 2.0), single beat -> result=0xFD00. Overflow: 0x7F00 x 0x7F00 -> result=0x7FFF, out_sat=1.
- Rounding: 0x0001 x 0x0080, single beat:
  - With FIXED_POINT_MAC_ROUND_EN: result=0x0001.
  - Without it: result=0x0000.
- Backpressure: out_ready=0 for 5 cycles during a stream of single-beat groups -> in_ready=0 while the output is held, result stable, all results delivered in order with none lost or duplicated.
- Reset mid-group: 2 non-last beats of 0x0100 x 0x0100, rst_n=0 for one cycle, then a single last beat 0x0100 x 0x0100 -> result=0x0100. No output from the pre-reset beats.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point MAC datapath.
// sat_signed works on a 64-bit signed container, so ACC_WIDTH+1 must not exceed 64.
package fixed_point_pkg;

  localparam int SAT_W = 64;

  typedef enum logic [0:0] {
    ACC_IDLE = 1'b0,
    ACC_BUSY = 1'b1
  } acc_state_e;

  // Right-shift that moves a product (2*frac_in fractional bits) to frac_out bits.
  function automatic int calc_shift(input int frac_in, input int frac_out);
    return (2 * frac_in) - frac_out;
  endfunction

  // Clamp a signed value into the range of a width-bit two's-complement word.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] value,
                                                         input int width);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/baugh_wooley_mult.sv
// Combinational signed multiplier using the Baugh-Wooley partial-product scheme.
// Partial products that pair exactly one sign bit are inverted; the constant
// 2^W + 2^(2W-1) restores the two's-complement result modulo 2^(2W).
module baugh_wooley_mult #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};

  logic [2*W-1:0] prod_s;
  logic           pp_s;

  // Sum all weighted partial products plus the Baugh-Wooley correction constant.
  always_comb begin
    prod_s = {(2*W){1'b0}};
    pp_s   = 1'b0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if ((i == W - 1) != (j == W - 1)) begin
          pp_s = ~(a[i] & b[j]);
        end else begin
          pp_s = a[i] & b[j];
        end
        prod_s = prod_s + ({{(2*W-1){1'b0}}, pp_s} << (i + j));
      end
    end
    prod_s = prod_s + (ONE << W) + (ONE << (2*W - 1));
  end

  assign p = prod_s;

endmodule

// File: rtl/fixed_point_round_sat.sv
// Requantiser: ACC_WIDTH sum -> WORD_WIDTH_OUT word with shift, optional
// rounding and saturation. Build option: FIXED_POINT_MAC_ROUND_EN selects
// round half-up; without it the arithmetic shift floors toward minus infinity.
module fixed_point_round_sat
  import fixed_point_pkg::*;
#(
  parameter int ACC_WIDTH      = 40,
  parameter int WORD_WIDTH_OUT = 16,
  parameter int SHIFT          = 8
) (
  input  logic signed [ACC_WIDTH-1:0]      sum,
  output logic        [WORD_WIDTH_OUT-1:0] result,
  output logic                             out_sat
);

`ifdef FIXED_POINT_MAC_ROUND_EN
  localparam logic signed [ACC_WIDTH:0] RND = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
`endif

  logic signed [ACC_WIDTH:0] ext_s;
  logic signed [ACC_WIDTH:0] biased_s;
  logic signed [ACC_WIDTH:0] shifted_s;
  logic signed [SAT_W-1:0]   wide_s;
  logic signed [SAT_W-1:0]   clamp_s;

  // Extend by one bit so the rounding bias can never wrap, then shift and clamp.
  always_comb begin
    ext_s     = {sum[ACC_WIDTH-1], sum};
`ifdef FIXED_POINT_MAC_ROUND_EN
    biased_s  = ext_s + RND;
`else
    biased_s  = ext_s;
`endif
    shifted_s = biased_s >>> SHIFT;
    wide_s    = {{(SAT_W-ACC_WIDTH-1){shifted_s[ACC_WIDTH]}}, shifted_s};
    clamp_s   = sat_signed(wide_s, WORD_WIDTH_OUT);
    out_sat   = (clamp_s != wide_s);
    result    = clamp_s[WORD_WIDTH_OUT-1:0];
  end

endmodule

// File: rtl/fixed_point_mac.sv
// Pipelined signed fixed-point multiply-accumulate with valid/ready flow control.
// Build option: FIXED_POINT_MAC_ROUND_EN (round half-up instead of truncation).
module fixed_point_mac
  import fixed_point_pkg::*;
#(
  parameter int WORD_WIDTH_IN  = 16,
  parameter int FRAC_BITS_IN   = 8,
  parameter int ACC_WIDTH      = 40,
  parameter int WORD_WIDTH_OUT = 16,
  parameter int FRAC_BITS_OUT  = 8,
  parameter int PIPE_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [WORD_WIDTH_IN-1:0]  multiplier,
  input  logic [WORD_WIDTH_IN-1:0]  multiplicand,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_WIDTH_OUT-1:0] result,
  output logic                      out_sat
);

  localparam int SHIFT = calc_shift(FRAC_BITS_IN, FRAC_BITS_OUT);
  localparam int PW    = 2 * WORD_WIDTH_IN;

  logic                  advance_s;
  logic [PW-1:0]         prod_s;
  logic [PW-1:0]         prod_pipe_r  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_pipe_r;
  logic [PIPE_STAGES-1:0] last_pipe_r;

  acc_state_e                   state_r;
  acc_state_e                   state_nxt_s;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic signed [ACC_WIDTH-1:0]  acc_nxt_s;
  logic signed [ACC_WIDTH-1:0]  acc_base_s;
  logic signed [ACC_WIDTH-1:0]  prod_ext_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic                         load_s;
  logic [WORD_WIDTH_OUT-1:0]    rs_result_s;
  logic                         rs_sat_s;

  // A single global enable: everything moves unless a result is waiting on downstream.
  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

  baugh_wooley_mult #(.W(WORD_WIDTH_IN)) u_mult (
    .a (multiplier),
    .b (multiplicand),
    .p (prod_s)
  );

  // Product pipeline; bubbles travel as valid=0 and everything freezes on a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        prod_pipe_r[k] <= {PW{1'b0}};
      end
      valid_pipe_r <= {PIPE_STAGES{1'b0}};
      last_pipe_r  <= {PIPE_STAGES{1'b0}};
    end else if (advance_s) begin
      prod_pipe_r[0]  <= prod_s;
      valid_pipe_r[0] <= in_valid;
      last_pipe_r[0]  <= in_last;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        prod_pipe_r[k]  <= prod_pipe_r[k-1];
        valid_pipe_r[k] <= valid_pipe_r[k-1];
        last_pipe_r[k]  <= last_pipe_r[k-1];
      end
    end
  end

  // Accumulate datapath: sign-extended product added to the running sum (wraps silently).
  always_comb begin
    prod_ext_s = ACC_WIDTH'($signed(prod_pipe_r[PIPE_STAGES-1]));
    if (state_r == ACC_IDLE) begin
      acc_base_s = {ACC_WIDTH{1'b0}};
    end else begin
      acc_base_s = acc_r;
    end
    sum_s = acc_base_s + prod_ext_s;
  end

  fixed_point_round_sat #(
    .ACC_WIDTH      (ACC_WIDTH),
    .WORD_WIDTH_OUT (WORD_WIDTH_OUT),
    .SHIFT          (SHIFT)
  ) u_round_sat (
    .sum     (sum_s),
    .result  (rs_result_s),
    .out_sat (rs_sat_s)
  );

  // Group FSM next state: open a group on a non-last beat, close it on a last beat.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    load_s      = 1'b0;
    if (advance_s && valid_pipe_r[PIPE_STAGES-1]) begin
      if (last_pipe_r[PIPE_STAGES-1]) begin
        load_s      = 1'b1;
        acc_nxt_s   = {ACC_WIDTH{1'b0}};
        state_nxt_s = ACC_IDLE;
      end else begin
        case (state_r)
          ACC_IDLE: begin
            acc_nxt_s   = sum_s;
            state_nxt_s = ACC_BUSY;
          end
          ACC_BUSY: begin
            acc_nxt_s   = sum_s;
            state_nxt_s = ACC_BUSY;
          end
          default: begin
            acc_nxt_s   = {ACC_WIDTH{1'b0}};
            state_nxt_s = ACC_IDLE;
          end
        endcase
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // FSM state and accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ACC_IDLE;
      acc_r   <= {ACC_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
    end
  end

  // Output register: load a new result, else drop valid on handshake, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {WORD_WIDTH_OUT{1'b0}};
      out_sat   <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      result    <= rs_result_s;
      out_sat   <= rs_sat_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_point_mac.sv
// Self-checking bench for fixed_point_mac (default Q8.8 in/out, SHIFT=8).
// Honours FIXED_POINT_MAC_ROUND_EN when choosing rounding expectations.
module tb_fixed_point_mac;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] multiplier;
  logic [15:0] multiplicand;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        out_sat;

  int          errors = 0;
  int          checks = 0;
  int          pushed = 0;
  int          popped = 0;
  longint      grp    = 0;
  logic [16:0] exp_q[$];
  logic [16:0] e_v;

  fixed_point_mac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .out_sat      (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scale a group sum to Q8.8 with rounding/truncation and saturation.
  function automatic logic [16:0] exp_of(input longint s);
    longint v;
    v = s;
`ifdef FIXED_POINT_MAC_ROUND_EN
    v = v + 64'sd128;
`endif
    v = v >>> 8;
    if (v > 64'sd32767) return {1'b1, 16'h7FFF};
    else if (v < -64'sd32768) return {1'b1, 16'h8000};
    else return {1'b0, v[15:0]};
  endfunction

  // Drive one beat and wait (bounded) for acceptance; push the expectation on a last beat.
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last,
                      input logic use_c, input logic [15:0] cres, input logic csat);
    logic ok;
    logic rdy;
    ok           = 1'b0;
    in_valid     = 1'b1;
    multiplier   = a;
    multiplicand = b;
    in_last      = last;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept_timeout", {31'd0, ok}, 32'd1);
    if (ok) begin
      grp = grp + (longint'($signed(a)) * longint'($signed(b)));
      if (last) begin
        if (use_c) exp_q.push_back({csat, cres});
        else exp_q.push_back(exp_of(grp));
        pushed++;
        grp = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e_v = exp_q.pop_front();
        popped++;
        check("result", {16'd0, result}, {16'd0, e_v[15:0]});
        check("out_sat", {31'd0, out_sat}, {31'd0, e_v[16]});
      end
    end
  end

  initial begin
    logic [15:0] held;
    logic        seen;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    multiplier   = 16'h0000;
    multiplicand = 16'h0000;
    out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);

    // Single beat with latency: 1.5 x 2.0 = 3.0
    beat(16'h0180, 16'h0200, 1'b1, 1'b1, 16'h0300, 1'b0);
    check("lat_t1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_t2", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_t3", {31'd0, out_valid}, 32'd1);
    idle(4);

    // Three-beat group of 1.0 x 1.0
    beat(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("grp_no_out1", {31'd0, out_valid}, 32'd0);
    beat(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("grp_no_out2", {31'd0, out_valid}, 32'd0);
    beat(16'h0100, 16'h0100, 1'b1, 1'b1, 16'h0300, 1'b0);
    idle(5);

    // Negative, overflow and rounding single beats
    beat(16'hFE80, 16'h0200, 1'b1, 1'b1, 16'hFD00, 1'b0);
    beat(16'h7F00, 16'h7F00, 1'b1, 1'b1, 16'h7FFF, 1'b1);
`ifdef FIXED_POINT_MAC_ROUND_EN
    beat(16'h0001, 16'h0080, 1'b1, 1'b1, 16'h0001, 1'b0);
`else
    beat(16'h0001, 16'h0080, 1'b1, 1'b1, 16'h0000, 1'b0);
`endif
    idle(5);

    // Randomised multi-beat groups against the reference model
    for (int g = 0; g < 6; g++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int k = 1; k <= n; k++) begin
        beat(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             (k == n), 1'b0, 16'h0000, 1'b0);
      end
    end
    idle(5);

    // Backpressure: hold out_ready low for 5 cycles during a stream
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          beat(16'(k * 64), 16'h0300, 1'b1, 1'b0, 16'h0000, 1'b0);
        end
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
          @(posedge clk); #1;
        end
        check("bp_out_seen", {31'd0, seen}, 32'd1);
        held = result;
        repeat (5) begin
          @(posedge clk); #1;
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_result_stable", {16'd0, result}, {16'd0, held});
        end
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Reset mid-group discards the partial sum and in-flight beats
    beat(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0);
    beat(16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    grp   = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    beat(16'h0100, 16'h0100, 1'b1, 1'b1, 16'h0100, 1'b0);
    idle(10);

    check("queue_drained", exp_q.size(), 32'd0);
    check("pop_count", popped, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
